lsu_ctrl: RTL and testbench

LSU_CTRL -- requirements
Module: lsu_ctrl

---
 rtl/lsu_pkg.sv | 56 +++++
 rtl/lsu_ctrl_load_ext.sv | 46 ++++
 rtl/lsu_ctrl.sv | 124 ++++++++++++
 tb/tb_lsu_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-size encodings,
// controller state type and the address-to-lane helpers used by lsu_ctrl.
package lsu_pkg;

  localparam int WORD_WIDTH = 32;

  // RISC-V funct3 size encodings
  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } lsu_state_e;

  // Legal size and naturally aligned for that size
  function automatic logic access_ok(input logic [2:0] size, input logic [1:0] off);
    logic ok;
    case (size)
      LDST_B, LDST_BU: ok = 1'b1;
      LDST_H, LDST_HU: ok = ~off[0];
      LDST_W:          ok = (off == 2'b00);
      default:         ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Byte enables for the addressed lanes
  function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] off);
    logic [3:0] be;
    case (size)
      LDST_B, LDST_BU: be = 4'b0001 << off;
      LDST_H, LDST_HU: be = 4'b0011 << {off[1], 1'b0};
      LDST_W:          be = 4'b1111;
      default:         be = 4'b0000;
    endcase
    return be;
  endfunction

  // Replicate right-aligned store data across every lane it may land in
  function automatic logic [WORD_WIDTH-1:0] lane_data(input logic [2:0] size,
                                                      input logic [WORD_WIDTH-1:0] wd);
    logic [WORD_WIDTH-1:0] d;
    case (size)
      LDST_B, LDST_BU: d = {4{wd[7:0]}};
      LDST_H, LDST_HU: d = {2{wd[15:0]}};
      default:         d = wd;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/lsu_ctrl_load_ext.sv
// Load data extraction: picks the addressed byte/half out of the memory
// word and sign- or zero-extends it to a right-aligned register value.
module load_ext
  import lsu_pkg::*;
(
  input  logic [WORD_WIDTH-1:0] mem_rd,
  input  logic [2:0]            size,
  input  logic [1:0]            addr,
  output logic [WORD_WIDTH-1:0] rd_next
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane selection by low address bits
  always_comb begin
    byte_s = 8'h00;
    half_s = 16'h0000;
    case (addr)
      2'd0:    byte_s = mem_rd[7:0];
      2'd1:    byte_s = mem_rd[15:8];
      2'd2:    byte_s = mem_rd[23:16];
      2'd3:    byte_s = mem_rd[31:24];
      default: byte_s = 8'h00;
    endcase
    if (addr[1]) begin
      half_s = mem_rd[31:16];
    end else begin
      half_s = mem_rd[15:0];
    end
  end

  // Extension according to access size
  always_comb begin
    rd_next = '0;
    case (size)
      LDST_B:  rd_next = {{24{byte_s[7]}}, byte_s};
      LDST_BU: rd_next = {24'h000000, byte_s};
      LDST_H:  rd_next = {{16{half_s[15]}}, half_s};
      LDST_HU: rd_next = {16'h0000, half_s};
      LDST_W:  rd_next = mem_rd;
      default: rd_next = mem_rd;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: accepts one core access at a time, checks
// alignment, runs a single memory transaction from latched registers and
// returns extended load data. The core is stalled until the DONE cycle.
module lsu_ctrl
  import lsu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  core_req,
  input  logic                  core_we,
  input  logic [2:0]            core_size,
  input  logic [WORD_WIDTH-1:0] core_addr,
  input  logic [WORD_WIDTH-1:0] core_wd,
  output logic [WORD_WIDTH-1:0] core_rd,
  output logic                  core_stall,
  output logic                  core_err,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [3:0]            mem_be,
  output logic [WORD_WIDTH-1:0] mem_addr,
  output logic [WORD_WIDTH-1:0] mem_wd,
  input  logic [WORD_WIDTH-1:0] mem_rd,
  input  logic                  mem_ready
);

  lsu_state_e            state_r;
  lsu_state_e            next_s;
  logic                  we_r;
  logic [3:0]            be_r;
  logic [WORD_WIDTH-1:0] addr_r;
  logic [WORD_WIDTH-1:0] wd_r;
  logic [2:0]            size_r;
  logic [1:0]            off_r;
  logic                  err_r;
  logic                  ok_s;
  logic                  busy_s;
  logic [WORD_WIDTH-1:0] ext_s;

  assign ok_s   = access_ok(core_size, core_addr[1:0]);
  assign busy_s = (state_r == ST_BUSY);

  // Memory side comes only from latched registers, gated by BUSY
  assign mem_req    = busy_s;
  assign mem_we     = busy_s & we_r;
  assign mem_be     = busy_s ? be_r : 4'b0000;
  assign mem_addr   = addr_r;
  assign mem_wd     = wd_r;
  assign core_stall = core_req & (state_r != ST_DONE);
  assign core_err   = (state_r == ST_DONE) & err_r;

  load_ext u_load_ext (
    .mem_rd  (mem_rd),
    .size    (size_r),
    .addr    (off_r),
    .rd_next (ext_s)
  );

  // Next-state logic
  always_comb begin
    next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (core_req) begin
          next_s = ok_s ? ST_BUSY : ST_DONE;
        end else begin
          next_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (mem_ready) begin
          next_s = ST_DONE;
        end else begin
          next_s = ST_BUSY;
        end
      end
      ST_DONE: next_s = ST_IDLE;
      default: next_s = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // Capture the access on acceptance; a rejected access only flags the error
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_r   <= 1'b0;
      be_r   <= 4'b0000;
      addr_r <= '0;
      wd_r   <= '0;
      size_r <= 3'd0;
      off_r  <= 2'd0;
      err_r  <= 1'b0;
    end else if ((state_r == ST_IDLE) && core_req) begin
      if (ok_s) begin
        we_r   <= core_we;
        be_r   <= byte_en(core_size, core_addr[1:0]);
        addr_r <= {core_addr[WORD_WIDTH-1:2], 2'b00};
        wd_r   <= lane_data(core_size, core_wd);
        size_r <= core_size;
        off_r  <= core_addr[1:0];
        err_r  <= 1'b0;
      end else begin
        err_r  <= 1'b1;
      end
    end
  end

  // Load result register, updated only when a load completes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      core_rd <= '0;
    end else if (busy_s && mem_ready && !we_r) begin
      core_rd <= ext_s;
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: a table of accesses is issued, the
// expected outcome of each is queued on issue and compared when the
// controller releases the stall. Includes reset-abort and idle mem_ready.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_req;
  logic        core_we;
  logic [2:0]  core_size;
  logic [31:0] core_addr;
  logic [31:0] core_wd;
  logic [31:0] core_rd;
  logic        core_stall;
  logic        core_err;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;
  logic        mem_ready;

  typedef struct packed {
    logic        we;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] mrd;
    logic [7:0]  dly;
    logic [31:0] rd;
    logic        err;
    logic [3:0]  be;
    logic [31:0] mwd;
  } vec_t;

  vec_t        exp_q[$];
  vec_t        tbl[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] last_rd = 32'h0;

  lsu_ctrl dut (
    .clk(clk), .rst(rst), .core_req(core_req), .core_we(core_we),
    .core_size(core_size), .core_addr(core_addr), .core_wd(core_wd),
    .core_rd(core_rd), .core_stall(core_stall), .core_err(core_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wd(mem_wd), .mem_rd(mem_rd), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [2:0] size, input logic [31:0] addr,
                              input logic [31:0] wd, input logic [31:0] mrd, input int dly,
                              input logic [31:0] rd, input logic err, input logic [3:0] be,
                              input logic [31:0] mwd);
    vec_t v;
    v.we = we; v.size = size; v.addr = addr; v.wd = wd; v.mrd = mrd;
    v.dly = 8'(dly); v.rd = rd; v.err = err; v.be = be; v.mwd = mwd;
    return v;
  endfunction

  // Issue one access, play the memory, then score the result
  task automatic run(input vec_t v);
    vec_t e;
    int   w = 0;
    int   stall_n = 0;
    int   req_n = 0;
    bit   done = 1'b0;
    e = v;
    if (v.we || v.err) e.rd = last_rd;
    last_rd = e.rd;
    exp_q.push_back(e);
    @(posedge clk); #1;
    core_req = 1'b1; core_we = v.we; core_size = v.size;
    core_addr = v.addr; core_wd = v.wd; mem_rd = v.mrd; mem_ready = 1'b0;
    @(negedge clk);
    chk("idle_req", {31'h0, mem_req}, 32'h0);
    chk("idle_be", {28'h0, mem_be}, 32'h0);
    for (int c = 0; c < 40 && !done; c++) begin
      if (c > 0) @(negedge clk);
      if (!core_stall) begin
        done = 1'b1;
      end else begin
        stall_n++;
        if (mem_req) begin
          req_n++;
          chk("mem_addr", mem_addr, {v.addr[31:2], 2'b00});
          chk("mem_be", {28'h0, mem_be}, {28'h0, v.be});
          chk("mem_we", {31'h0, mem_we}, {31'h0, v.we});
          if (v.we) chk("mem_wd", mem_wd, v.mwd);
          mem_ready = (w >= int'(v.dly));
          w++;
        end else begin
          mem_ready = 1'b0;
        end
      end
    end
    mem_ready = 1'b0;
    if (!done) chk("timeout", 32'h1, 32'h0);
    e = exp_q.pop_front();
    chk("core_err", {31'h0, core_err}, {31'h0, e.err});
    chk("core_rd", core_rd, e.rd);
    chk("stall_cycles", stall_n, e.err ? 32'd1 : 32'(2 + int'(e.dly)));
    chk("mem_req_cycles", req_n, e.err ? 32'd0 : 32'(1 + int'(e.dly)));
    @(posedge clk); #1;
    core_req = 1'b0;
    @(negedge clk);
    chk("err_pulse_end", {31'h0, core_err}, 32'h0);
    chk("no_reissue", {31'h0, mem_req}, 32'h0);
    chk("rd_held", core_rd, e.rd);
  endtask

  initial begin
    rst = 1'b0; core_req = 1'b0; core_we = 1'b0; core_size = 3'd0;
    core_addr = 32'h0; core_wd = 32'h0; mem_rd = 32'h0; mem_ready = 1'b0;
    #2;
    chk("rst_core_rd", core_rd, 32'h0);
    chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
    chk("rst_mem_be", {28'h0, mem_be}, 32'h0);
    chk("rst_core_err", {31'h0, core_err}, 32'h0);
    #20 rst = 1'b1;

    //          we    size  addr          wd            mrd           d  rd            err   be       mwd
    tbl.push_back(mk(1'b1, 3'd2, 32'h00000100, 32'hDEADBEEF, 32'h0,        0, 32'h0,        1'b0, 4'b1111, 32'hDEADBEEF));
    tbl.push_back(mk(1'b1, 3'd0, 32'h00000103, 32'h000000A5, 32'h0,        0, 32'h0,        1'b0, 4'b1000, 32'hA5A5A5A5));
    tbl.push_back(mk(1'b0, 3'd0, 32'h00000102, 32'h0,        32'h1280FF34, 0, 32'hFFFFFF80, 1'b0, 4'b0100, 32'h0));
    tbl.push_back(mk(1'b0, 3'd4, 32'h00000102, 32'h0,        32'h1280FF34, 0, 32'h00000080, 1'b0, 4'b0100, 32'h0));
    tbl.push_back(mk(1'b0, 3'd5, 32'h00000102, 32'h0,        32'h1280FF34, 0, 32'h00001280, 1'b0, 4'b1100, 32'h0));
    tbl.push_back(mk(1'b0, 3'd1, 32'h00000100, 32'h0,        32'h1280FF34, 1, 32'hFFFFFF34, 1'b0, 4'b0011, 32'h0));
    tbl.push_back(mk(1'b0, 3'd2, 32'h00000104, 32'h0,        32'hCAFEF00D, 3, 32'hCAFEF00D, 1'b0, 4'b1111, 32'h0));
    tbl.push_back(mk(1'b0, 3'd2, 32'h00000102, 32'h0,        32'h11111111, 0, 32'h0,        1'b1, 4'b0000, 32'h0));
    tbl.push_back(mk(1'b0, 3'd3, 32'h00000100, 32'h0,        32'h22222222, 0, 32'h0,        1'b1, 4'b0000, 32'h0));
    tbl.push_back(mk(1'b1, 3'd1, 32'h00000106, 32'h1234ABCD, 32'h0,        2, 32'h0,        1'b0, 4'b1100, 32'hABCDABCD));
    tbl.push_back(mk(1'b0, 3'd5, 32'h00000101, 32'h0,        32'h33333333, 0, 32'h0,        1'b1, 4'b0000, 32'h0));
    tbl.push_back(mk(1'b0, 3'd0, 32'h00000101, 32'h0,        32'h00007F00, 0, 32'h0000007F, 1'b0, 4'b0010, 32'h0));
    tbl.push_back(mk(1'b0, 3'd7, 32'h00000200, 32'h0,        32'h44444444, 0, 32'h0,        1'b1, 4'b0000, 32'h0));
    foreach (tbl[i]) run(tbl[i]);

    // mem_ready while idle must be ignored
    @(posedge clk); #1;
    mem_ready = 1'b1; mem_rd = 32'h99999999;
    @(negedge clk);
    chk("idle_ready_req", {31'h0, mem_req}, 32'h0);
    @(negedge clk);
    chk("idle_ready_rd", core_rd, last_rd);
    mem_ready = 1'b0;

    // Reset in the middle of a load aborts the memory access at once
    @(posedge clk); #1;
    core_req = 1'b1; core_we = 1'b0; core_size = 3'd2; core_addr = 32'h00000108;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_req", {31'h0, mem_req}, 32'h1);
    #2 rst = 1'b0;
    #1;
    chk("rst_abort_req", {31'h0, mem_req}, 32'h0);
    chk("rst_abort_be", {28'h0, mem_be}, 32'h0);
    chk("rst_abort_rd", core_rd, 32'h0);
    @(posedge clk); #1;
    core_req = 1'b0;
    #2 rst = 1'b1;
    last_rd = 32'h0;

    run(mk(1'b1, 3'd0, 32'h00000110, 32'h0000005A, 32'h0, 0, 32'h0, 1'b0, 4'b0001, 32'h5A5A5A5A));
    run(mk(1'b0, 3'd4, 32'h00000113, 32'h0, 32'h9C000000, 1, 32'h0000009C, 1'b0, 4'b1000, 32'h0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Absolute time limit so a hung controller still ends the run
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
